// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StWaitWord,
        StWrite,
        StHold,
        StRun
    } state_e;

    // Bytes per instruction word, written low byte first.
    localparam int unsigned ByteLanes = 4;
    localparam logic [1:0]  LastBeat  = 2'(ByteLanes - 1);

    // Select one little-endian byte lane from a 32-bit word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader word stream plus byte-wide instruction RAM write port.
interface imem_boot_ctrl_if #(
    parameter int unsigned ADDR_W = 10
) ();

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    // Loader / RAM side.
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );

    // Boot controller side.
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/imem_boot_ctrl_word_serializer.sv
// Latches one 32-bit word and plays it out as four registered byte writes
// at base_i+0..3. beat_done_o is high while the final beat is on the bus.
module word_serializer
    import imem_boot_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [31:0]       word_i,
    input  logic              wr_en_i,    // low: run the beats without writing
    input  logic [ADDR_W-1:0] base_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              beat_done_o
);

    logic              active_q, active_d;
    logic [1:0]        beat_q, beat_d;
    logic [31:0]       word_q, word_d;
    logic              wr_en_q, wr_en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [1:0]        beat_nxt;

    assign beat_nxt = beat_q + 2'd1;

    // Next beat: a load presents byte 0 immediately, then one byte per cycle.
    always_comb begin
        active_d = active_q;
        beat_d   = beat_q;
        word_d   = word_q;
        wr_en_d  = wr_en_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (load_i) begin
            active_d = 1'b1;
            beat_d   = 2'd0;
            word_d   = word_i;
            wr_en_d  = wr_en_i;
            we_d     = wr_en_i;
            waddr_d  = base_i;
            wdata_d  = lane_byte(word_i, 2'd0);
        end else if (active_q) begin
            if (beat_q == LastBeat) begin
                active_d = 1'b0;
            end else begin
                beat_d  = beat_nxt;
                we_d    = wr_en_q;
                waddr_d = base_i + ADDR_W'(beat_nxt);
                wdata_d = lane_byte(word_q, beat_nxt);
            end
        end
    end

    // Beat state and registered write-port outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            beat_q   <= 2'd0;
            word_q   <= '0;
            wr_en_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            active_q <= active_d;
            beat_q   <= beat_d;
            word_q   <= word_d;
            wr_en_q  <= wr_en_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = wdata_q;
    assign beat_done_o = active_q && (beat_q == LastBeat);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: holds the core in reset, writes a loaded image into the
// byte-wide instruction RAM, then releases the core after a fixed hold time.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    imem_boot_ctrl_if.slave   bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] words
);

    localparam int unsigned RamBytes = 2 ** ADDR_W;
    // One extra bit so base can sit at RamBytes once the RAM is full.
    localparam int unsigned BaseW    = ADDR_W + 1;
    localparam int unsigned HoldW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned WordsW   = ADDR_W - 1;

    state_e             state_q, state_d;
    logic [BaseW-1:0]   base_q, base_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [WordsW-1:0]  words_q, words_d;
    logic               err_q, err_d;
    logic               last_q, last_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;

    logic               accept;
    logic               overflow;
    logic               beat_done;
    logic               ser_we;
    logic [ADDR_W-1:0]  ser_waddr;
    logic [7:0]         ser_wdata;

    assign accept   = (state_q == StWaitWord) && in_ready_q && bus.in_valid;
    // A word starting past the last full slot is consumed but not written.
    assign overflow = base_q > BaseW'(RamBytes - 4);

    word_serializer #(
        .ADDR_W (ADDR_W)
    ) u_ser (
        .clk_i       (clock),
        .rst_ni      (rst_n),
        .load_i      (accept),
        .word_i      (bus.in_data),
        .wr_en_i     (!overflow),
        .base_i      (base_q[ADDR_W-1:0]),
        .mem_we_o    (ser_we),
        .mem_waddr_o (ser_waddr),
        .mem_wdata_o (ser_wdata),
        .beat_done_o (beat_done)
    );

    // Sequencing and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        hold_d     = hold_q;
        words_d    = words_q;
        err_d      = err_q;
        last_d     = last_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        in_ready_d = in_ready_q;
        case (state_q)
            StIdle, StRun: begin
                if (start) begin
                    state_d    = StWaitWord;
                    base_d     = '0;
                    words_d    = '0;
                    err_d      = 1'b0;
                    cpu_rst_d  = 1'b1;
                    done_d     = 1'b0;
                    in_ready_d = 1'b1;
                end
            end
            StWaitWord: begin
                if (accept) begin
                    state_d    = StWrite;
                    in_ready_d = 1'b0;
                    last_d     = bus.in_last;
                    words_d    = (&words_q) ? words_q : words_q + WordsW'(1);
                    if (overflow) begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                if (beat_done) begin
                    base_d = overflow ? base_q : base_q + BaseW'(4);
                    if (last_q) begin
                        state_d = StHold;
                        hold_d  = HoldW'(RST_HOLD - 1);
                    end else begin
                        state_d    = StWaitWord;
                        in_ready_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (hold_q == '0) begin
                    state_d   = StRun;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            hold_q     <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            hold_q     <= hold_d;
            words_q    <= words_d;
            err_q      <= err_d;
            last_q     <= last_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = ser_we;
    assign bus.mem_waddr = ser_waddr;
    assign bus.mem_wdata = ser_wdata;
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words         = words_q;

endmodule
